// File: rtl/piso_serial_tx.sv
//======================================================================
// Module      : piso_serial_tx
// Description : Parallel-in, serial-out framed transmitter (start, LSB-first
//               data, optional even parity, stop) with a valid/ready load.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module piso_serial_tx #(
    parameter int NBITS_DATA = 4,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1
) (
    input  logic                          clk_2,
    input  logic                          reset,
    input  logic [NBITS_DATA-1:0]         data_in_parallel,
    input  logic                          load,
    output logic                          ready,
    output logic                          busy,
    output logic                          serial_out,
    output logic                          done,
    output logic [$clog2(NBITS_DATA)-1:0] bit_index
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = $clog2(NBITS_DATA);

    localparam logic [CW-1:0] c_CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NBITS_DATA - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [NBITS_DATA-1:0] r_shift;
    logic                  r_par;
    logic [IW-1:0]         r_idx;
    logic                  r_serial;
    logic                  r_done;

    logic [2:0]            w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [NBITS_DATA-1:0] w_shift_nxt;
    logic                  w_par_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_done_nxt;
    logic                  w_serial_nxt;
    logic                  w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (load) begin
                    w_shift_nxt = data_in_parallel;
                    w_par_nxt   = ^data_in_parallel;
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            c_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // The line level is decoded from the next state so the flop already holds
    // the start bit in the cycle right after the accepting edge.
    always_comb begin
        w_serial_nxt = 1'b1;
        case (w_state_nxt)
            c_START:  w_serial_nxt = 1'b0;
            c_DATA:   w_serial_nxt = w_shift_nxt[0];
            c_PARITY: w_serial_nxt = w_par_nxt;
            default:  w_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_idx    <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_idx    <= w_idx_nxt;
            r_serial <= w_serial_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign ready      = (r_state == c_IDLE);
    assign busy       = ~ready;
    assign serial_out = r_serial;
    assign done       = r_done;
    assign bit_index  = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
//======================================================================
// Module      : tb_piso_serial_tx
// Description : Scoreboard bench for piso_serial_tx; two instances
//               (1 cycle/bit with parity, 3 cycles/bit without parity).
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_piso_serial_tx;

    typedef struct packed {
        logic [63:0]  line;
        logic [127:0] idx;
        logic [7:0]   len;
        logic [3:0]   word;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] data;
    logic       end_req;

    logic [1:0] rdy;
    logic [1:0] bsy;
    logic [1:0] so;
    logic [1:0] dn;
    logic [1:0] bidx [2];

    int n_tests = 0;
    int n_fail  = 0;

    frame_t fr [2][256];
    int     wr [2];
    int     mb [2];
    int     rd [2];
    logic   act [2];
    int     pos [2];
    logic [3:0] lb [2];
    frame_t cur [2];
    logic   end_done;

    always #5 clk = ~clk;

    function automatic int bc_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int pe_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            piso_serial_tx #(
                .NBITS_DATA(4),
                .BIT_CYCLES((k == 0) ? 1 : 3),
                .PARITY_EN ((k == 0) ? 1 : 0)
            ) u_dut (
                .clk_2           (clk),
                .reset           (reset),
                .data_in_parallel(data),
                .load            (load),
                .ready           (rdy[k]),
                .busy            (bsy[k]),
                .serial_out      (so[k]),
                .done            (dn[k]),
                .bit_index       (bidx[k])
            );
        end
    endgenerate

    // Reference frame: list of line symbols, each stretched to bc cycles.
    function automatic frame_t build(input logic [3:0] w, input int bc, input int pe);
        frame_t f;
        int     p;
        int     nb;
        logic   b;
        f  = '0;
        p  = 0;
        nb = 6 + pe;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)                b = 1'b0;
            else if (i <= 4)           b = w[i-1];
            else if (i == 5 && pe != 0) b = ($countones(w) % 2) == 1;
            else                       b = 1'b1;
            for (int c = 0; c < bc; c++) begin
                f.line[p] = b;
                f.idx[2*p +: 2] = (i >= 1 && i <= 4) ? 2'(i - 1) : 2'd0;
                p++;
            end
        end
        f.len  = 8'(p);
        f.word = w;
        return f;
    endfunction

    // Model: acceptance decided from its own idea of when the transmitter is free.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mb[k] = 0;
            end else if (mb[k] == 0 && load) begin
                fr[k][wr[k] % 256] = build(data, bc_of(k), pe_of(k));
                mb[k] = (6 + pe_of(k)) * bc_of(k);
                wr[k] = wr[k] + 1;
            end else if (mb[k] > 0) begin
                mb[k] = mb[k] - 1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", nm, k, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                act[k] = 1'b0;
                rd[k]  = wr[k];
                chk("rst_serial", k, 32'(so[k]), 32'd1);
                chk("rst_ready",  k, 32'(rdy[k]), 32'd1);
                chk("rst_done",   k, 32'(dn[k]), 32'd0);
                chk("rst_bidx",   k, 32'(bidx[k]), 32'd0);
            end else begin
                if (!act[k] && !rdy[k]) begin
                    chk("frame_expected", k, 32'(wr[k] != rd[k]), 32'd1);
                    if (wr[k] != rd[k]) begin
                        cur[k] = fr[k][rd[k] % 256];
                        rd[k]  = rd[k] + 1;
                        act[k] = 1'b1;
                        pos[k] = 0;
                        lb[k]  = 4'd0;
                    end
                end
                if (act[k]) begin
                    if (pos[k] == int'(cur[k].len)) begin
                        chk("end_done",     k, 32'(dn[k]), 32'd1);
                        chk("end_ready",    k, 32'(rdy[k]), 32'd1);
                        chk("end_serial",   k, 32'(so[k]), 32'd1);
                        chk("loopback_word", k, 32'(lb[k]), 32'(cur[k].word));
                        act[k] = 1'b0;
                    end else begin
                        chk("serial", k, 32'(so[k]), 32'(cur[k].line[pos[k]]));
                        chk("busy_ready", k, 32'(rdy[k]), 32'd0);
                        chk("busy_flag", k, 32'(bsy[k]), 32'd1);
                        chk("busy_done", k, 32'(dn[k]), 32'd0);
                        chk("bit_index", k, 32'(bidx[k]), 32'(cur[k].idx[2*pos[k] +: 2]));
                        if (pos[k] >= bc_of(k) && pos[k] < 5 * bc_of(k) &&
                            (pos[k] % bc_of(k)) == bc_of(k) - 1)
                            lb[k] = {so[k], lb[k][3:1]};
                        pos[k] = pos[k] + 1;
                    end
                end else if (rdy[k]) begin
                    chk("idle_serial", k, 32'(so[k]), 32'd1);
                    chk("idle_done",   k, 32'(dn[k]), 32'd0);
                    chk("idle_busy",   k, 32'(bsy[k]), 32'd0);
                    chk("idle_bidx",   k, 32'(bidx[k]), 32'd0);
                end
            end
            if (end_req && !end_done) begin
                chk("all_frames_seen", k, 32'(wr[k] - rd[k]), 32'd0);
                chk("no_frame_open",   k, 32'(act[k]), 32'd0);
            end
        end
        if (end_req) end_done = 1'b1;
    end

    task automatic cyc(input logic l, input logic [3:0] d);
        load = l;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        load  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; rd[k] = 0; mb[k] = 0; act[k] = 1'b0; pos[k] = 0; lb[k] = 4'd0;
        end
        end_req  = 1'b0;
        end_done = 1'b0;
        reset    = 1'b1;
        load     = 1'b0;
        data     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 4'd0);

        // Basic frames; data wiggles after acceptance.
        cyc(1'b1, 4'b1011);
        repeat (20) cyc(1'b0, 4'($urandom));
        cyc(1'b1, 4'b0110);
        repeat (20) cyc(1'b0, 4'($urandom));

        // Load re-pulsed while busy is ignored.
        cyc(1'b1, 4'b0000);
        repeat (2) cyc(1'b0, 4'b0000);
        cyc(1'b1, 4'b1111);
        repeat (20) cyc(1'b0, 4'b0000);

        // Reset during the third data bit, load held high through reset.
        cyc(1'b1, 4'b1011);
        repeat (3) cyc(1'b0, 4'b1011);
        pulse_reset();
        cyc(1'b1, 4'b0001);
        repeat (20) cyc(1'b0, 4'b0000);

        // Load held high across the done cycle, data switched for the second frame.
        cyc(1'b1, 4'b1010);
        repeat (7) cyc(1'b1, 4'b1010);
        cyc(1'b1, 4'b0101);
        repeat (20) cyc(1'b0, 4'($urandom));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 80) == 0)
                pulse_reset();
            else
                cyc($urandom_range(0, 3) == 0, 4'($urandom));
        end
        repeat (30) cyc(1'b0, 4'd0);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
